// File: rtl/slip_pkg.sv
// slip_pkg: shared definitions for the SLIP escaper/unescaper pair.
//   - Default framing symbols (END, ESC and the two escaped forms).
//   - Escaper FSM state encoding.
package slip_pkg;

  localparam int unsigned SYMBOL_WIDTH_DEF = 8;

  localparam logic [7:0] SYMBOL_END_DEF     = 8'hC0;
  localparam logic [7:0] SYMBOL_ESC_DEF     = 8'hDB;
  localparam logic [7:0] SYMBOL_ESC_END_DEF = 8'hDC;
  localparam logic [7:0] SYMBOL_ESC_ESC_DEF = 8'hDD;

  typedef enum logic {
    ST_PASS,
    ST_SECOND
  } slip_state_e;

endpackage

// File: rtl/slip_escaper.sv
// slip_escaper: transmit-side SLIP stream escaper.
//   Converts an input beat stream (data or frame-end marker) into a single
//   symbol stream: end beats become SYMBOL_END, in-band END/ESC data become
//   two-symbol ESC sequences, everything else passes through. Output is
//   registered.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_data, i_end         input symbol / frame-end flag (data ignored on end)
//   i_valid, o_ready      input handshake
//   o_data, o_valid       registered output symbol / valid
//   i_ready               downstream ready
module slip_escaper
  import slip_pkg::*;
#(
  parameter int unsigned                SYMBOL_WIDTH   = SYMBOL_WIDTH_DEF,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_END     = SYMBOL_END_DEF,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_ESC     = SYMBOL_ESC_DEF,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_ESC_END = SYMBOL_ESC_END_DEF,
  parameter logic [SYMBOL_WIDTH-1:0]    SYMBOL_ESC_ESC = SYMBOL_ESC_ESC_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [SYMBOL_WIDTH-1:0] i_data,
  input  logic                    i_end,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [SYMBOL_WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready
);

  slip_state_e             state_q, state_d;
  logic [SYMBOL_WIDTH-1:0] pending_q, pending_d;
  logic [SYMBOL_WIDTH-1:0] o_data_q, o_data_d;
  logic                    o_valid_q, o_valid_d;

  logic load_en;
  logic accept;

  // Output register may take a new symbol when empty or being drained.
  assign load_en = !o_valid_q || i_ready;
  assign o_ready = (state_q == ST_PASS) && load_en && !i_rst;
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;

    unique case (state_q)
      ST_PASS: begin
        if (accept) begin
          o_valid_d = 1'b1;
          if (i_end) begin
            o_data_d = SYMBOL_END;
          end else if (i_data == SYMBOL_END) begin
            o_data_d  = SYMBOL_ESC;
            pending_d = SYMBOL_ESC_END;
            state_d   = ST_SECOND;
          end else if (i_data == SYMBOL_ESC) begin
            o_data_d  = SYMBOL_ESC;
            pending_d = SYMBOL_ESC_ESC;
            state_d   = ST_SECOND;
          end else begin
            o_data_d = i_data;
          end
        end else if (i_ready) begin
          o_valid_d = 1'b0;
        end
      end
      ST_SECOND: begin
        // Without load_en the register is stalled (valid && !ready): hold.
        if (load_en) begin
          o_data_d  = pending_q;
          o_valid_d = 1'b1;
          state_d   = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_PASS;
      pending_q <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: doc/slip_escaper.md
# slip_escaper

Transmit-side SLIP-style stream escaper, the counterpart of `slip_unescaper`. It accepts an AXIS-like symbol stream carrying an `i_end` marker. It emits a single-width symbol stream in which frame ends are encoded as `SYMBOL_END` and any in-band `SYMBOL_END`/`SYMBOL_ESC` data symbols are replaced by two-symbol escape sequences. It sits between packet producers (response/sample framers) and the byte-wide host link, and its output is registered.

## Interface
- `SYMBOL_WIDTH`, 8, symbol width in bits
- `SYMBOL_END`, 8'hC0, frame terminator symbol
- `SYMBOL_ESC`, 8'hDB, escape prefix
- `SYMBOL_ESC_END`, 8'hDC, escaped form of END (follows ESC)
- `SYMBOL_ESC_ESC`, 8'hDD, escaped form of ESC (follows ESC)

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_data` in SYMBOL_WIDTH: input symbol. Ignored when `i_end`=1.
- `i_end` in 1: this beat is a frame end; emit `SYMBOL_END`.
- `i_valid` in 1: input beat valid.
- `o_ready` out 1: input beat accepted when `i_valid && o_ready`.
- `o_data` out SYMBOL_WIDTH: output symbol (registered).
- `o_valid` out 1: output valid (registered).
- `i_ready` in 1: downstream ready.

## Operation
- Output register (`o_data`, `o_valid`) is loadable when `load_en = !o_valid || i_ready`.
- FSM states:
  - `ST_PASS`: `o_ready = load_en`. On accept:
    - `i_end`=1: load `SYMBOL_END`, stay in `ST_PASS`.
    - Else if `i_data == SYMBOL_END`: load `SYMBOL_ESC`, set `pending <= SYMBOL_ESC_END`, go to `ST_SECOND`.
    - Else if `i_data == SYMBOL_ESC`: load `SYMBOL_ESC`, set `pending <= SYMBOL_ESC_ESC`, go to `ST_SECOND`.
    - Else: load `i_data` unchanged.
  - `ST_SECOND`: `o_ready = 0`. When `load_en`, load `pending` and return to `ST_PASS`.
- If nothing is loaded while `i_ready`=1, `o_valid` clears.
- `SYMBOL_ESC_END` and `SYMBOL_ESC_ESC` appearing as plain data pass through unescaped. Per the unescaper's rules, they are only reinterpreted after an ESC.
- Escaped symbols and END markers never collapse. Every input beat produces exactly 1 output symbol (plain or end) or 2 (escaped).
- Any output of this block fed through `slip_unescaper` reproduces the original beat sequence, with end beats appearing as `o_end`=1, data 0.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, state `ST_PASS`, `pending`=0. `o_ready` is forced to 0 while `i_rst`=1.
- Latency: an accepted beat appears on `o_data`/`o_valid` the next cycle.
- Throughput:
  - 1 symbol/cycle with `i_ready` held high.
  - Escaped beats take 2 output cycles, and the input is stalled 1 cycle.
- `o_ready` is combinational from `i_ready`, `o_valid` and state. There is no combinational path from `i_valid` or `i_data` to any output.
- While `o_valid && !i_ready`, `o_data` and `o_valid` hold stable (AXIS rule).
- Back-pressure in `ST_SECOND` holds `pending` indefinitely.
- A reset mid-escape discards the pending second symbol. The partial sequence (lone ESC) is tolerated by the unescaper.
- Simultaneous output handshake and input accept in the same cycle is the normal full-rate case and must not drop or duplicate a symbol.

## Structure
- Symbol defaults (`C0`/`DB`/`DC`/`DD`) and the state encoding (`ST_PASS`, `ST_SECOND`) go in a shared `slip_pkg` package, used by both `slip_escaper` and `slip_unescaper`.
- One natural sub-module is none required. The output register is inline; no separate skid buffer is needed.

## Test plan
- Reset, then idle: `o_valid`=0, `o_data`=0, `o_ready`=0 during reset and 1 after.
- Inputs 8'h01, 8'h02, then end, with `i_ready`=1: outputs 01, 02, C0 on consecutive cycles, starting 1 cycle after the first accept.
- Input data C0, then DB: outputs DB DC DB DD; `o_ready` low on the cycle after each accept.
- Input data DC, then DD: output DC DD unchanged, no stalls.
- Data C0 with `i_ready` toggling 1-0-0-1-1: DB held stable while stalled, then DC; no loss or duplication. A random-stall run of 1000 random beats (20% C0/DB, 10% end) looped through `slip_unescaper` reproduces the input exactly.
- Reset asserted in `ST_SECOND` after DB is emitted: next cycle `o_valid`=0, state `ST_PASS`; DC is never emitted.
